sleep_seq_ctrl: RTL and testbench

//  Power-mode sequencer for the SM83 core: owns CLK_ENA/OSC_ENA; decodes HALT/STOP entry.

---
 rtl/sleep_seq_ctrl.sv | 107 ++++++++++
 tb/tb_sleep_seq_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sleep_seq_ctrl.sv
// rtl/sleep_seq_ctrl.sv - SM83 power-mode sequencer (HALT/STOP entry, wake, oscillator wait)
module sleep_seq_ctrl #(
   parameter int CNT_W       = 10,
   parameter int STAB_CYCLES = 512
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       HALT_REQ,
   input  logic       STOP_REQ,
   input  logic       IRQ_PEND,
   input  logic       IME,
   input  logic       JOYP_WAKE,
   output logic       CLK_ENA,
   output logic       OSC_ENA,
   output logic       HALT_BUG,
   output logic       WAKE_ACK,
   output logic [1:0] STATE
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_HALT     = 2'd1,
      S_STOP     = 2'd2,
      S_OSC_WAIT = 2'd3
   } state_t;

   // Loaded on STOP wake; the wait ends on the edge that sees zero, giving STAB_CYCLES cycles.
   localparam logic [CNT_W-1:0] STAB_LOAD = CNT_W'(STAB_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wake_nxt;
   logic             bug_nxt;
   logic             clk_ena_nxt;
   logic             osc_ena_nxt;

   // Next-state, counter and pulse decode; outputs are derived from the next state so they register with it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wake_nxt  = 1'b0;
      bug_nxt   = 1'b0;
      case (state)
         S_RUN: begin
            if (STOP_REQ) begin
               state_nxt = S_STOP;
            end else if (HALT_REQ) begin
               if (IRQ_PEND) begin
                  // Pending interrupt with IME clear: HALT falls through and the PC fails to advance.
                  bug_nxt = ~IME;
               end else begin
                  state_nxt = S_HALT;
               end
            end
         end
         S_HALT: begin
            if (IRQ_PEND) begin
               state_nxt = S_RUN;
               wake_nxt  = 1'b1;
            end
         end
         S_STOP: begin
            if (JOYP_WAKE) begin
               state_nxt = S_OSC_WAIT;
               cnt_nxt   = STAB_LOAD;
            end
         end
         S_OSC_WAIT: begin
            if (cnt == '0) begin
               state_nxt = S_RUN;
               wake_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_RUN;
         end
      endcase
      clk_ena_nxt = (state_nxt == S_RUN);
      osc_ena_nxt = (state_nxt != S_STOP);
   end

   // State, counter and all outputs registered together; reset returns to RUN with no stabilisation wait.
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state    <= S_RUN;
         cnt      <= '0;
         CLK_ENA  <= 1'b1;
         OSC_ENA  <= 1'b1;
         HALT_BUG <= 1'b0;
         WAKE_ACK <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         CLK_ENA  <= clk_ena_nxt;
         OSC_ENA  <= osc_ena_nxt;
         HALT_BUG <= bug_nxt;
         WAKE_ACK <= wake_nxt;
      end
   end

   assign STATE = state;

endmodule

// File: tb/tb_sleep_seq_ctrl.sv
// tb/tb_sleep_seq_ctrl.sv - scoreboard bench for sleep_seq_ctrl
module tb_sleep_seq_ctrl;

   logic       CLK;
   logic       nRESET;
   logic       HALT_REQ;
   logic       STOP_REQ;
   logic       IRQ_PEND;
   logic       IME;
   logic       JOYP_WAKE;
   logic       CLK_ENA;
   logic       OSC_ENA;
   logic       HALT_BUG;
   logic       WAKE_ACK;
   logic [1:0] STATE;

   sleep_seq_ctrl #(.CNT_W(2), .STAB_CYCLES(4)) dut (
      .CLK       (CLK),
      .nRESET    (nRESET),
      .HALT_REQ  (HALT_REQ),
      .STOP_REQ  (STOP_REQ),
      .IRQ_PEND  (IRQ_PEND),
      .IME       (IME),
      .JOYP_WAKE (JOYP_WAKE),
      .CLK_ENA   (CLK_ENA),
      .OSC_ENA   (OSC_ENA),
      .HALT_BUG  (HALT_BUG),
      .WAKE_ACK  (WAKE_ACK),
      .STATE     (STATE)
   );

   typedef struct {
      int         cyc;
      logic [5:0] val;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   // Expect {STATE, CLK_ENA, OSC_ENA, HALT_BUG, WAKE_ACK} after the next edge, then advance one cycle.
   task automatic step(input logic [1:0] st, input logic ce, input logic oe,
                       input logic hb, input logic wa, input string name);
      exp_t e;
      e.cyc  = cyc + 1;
      e.val  = {st, ce, oe, hb, wa};
      e.name = name;
      exp_q.push_back(e);
      @(negedge CLK);
   endtask

   // Monitor: pops every expectation due this cycle and compares against the live outputs.
   always @(negedge CLK) begin
      logic [5:0] act;
      act = {STATE, CLK_ENA, OSC_ENA, HALT_BUG, WAKE_ACK};
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s: missed sample cycle %0d (now %0d)", e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            errors++;
            $display("FAIL %s @%0d: got st/ce/oe/hb/wa=%b required %b", e.name, cyc, act, e.val);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nRESET = 1'b0; HALT_REQ = 1'b0; STOP_REQ = 1'b0;
      IRQ_PEND = 1'b0; IME = 1'b0; JOYP_WAKE = 1'b0;
      @(negedge CLK);
      // 1 reset held for two edges, then released
      step(2'd0, 1, 1, 0, 0, "reset");
      nRESET = 1'b1;
      step(2'd0, 1, 1, 0, 0, "run_idle");

      // 2 HALT entry, ignored requests, IRQ wake
      HALT_REQ = 1'b1;
      step(2'd1, 0, 1, 0, 0, "halt_enter");
      HALT_REQ = 1'b0;
      step(2'd1, 0, 1, 0, 0, "halt_hold");
      STOP_REQ = 1'b1; JOYP_WAKE = 1'b1; HALT_REQ = 1'b1;
      step(2'd1, 0, 1, 0, 0, "halt_ignores_req");
      STOP_REQ = 1'b0; JOYP_WAKE = 1'b0; HALT_REQ = 1'b0; IRQ_PEND = 1'b1;
      step(2'd0, 1, 1, 0, 1, "halt_wake_ack");
      IRQ_PEND = 1'b0;
      step(2'd0, 1, 1, 0, 0, "wake_ack_drop");

      // 3 HALT bug with IME=0, none with IME=1
      IRQ_PEND = 1'b1; IME = 1'b0; HALT_REQ = 1'b1;
      step(2'd0, 1, 1, 1, 0, "halt_bug_pulse");
      HALT_REQ = 1'b0;
      step(2'd0, 1, 1, 0, 0, "halt_bug_drop");
      IME = 1'b1; HALT_REQ = 1'b1;
      step(2'd0, 1, 1, 0, 0, "halt_ime_no_bug");
      HALT_REQ = 1'b0; IRQ_PEND = 1'b0; IME = 1'b0;
      step(2'd0, 1, 1, 0, 0, "run_after_ime");

      // 5 priority: STOP wins even when a HALT-bug condition is present
      HALT_REQ = 1'b1; STOP_REQ = 1'b1; IRQ_PEND = 1'b1;
      step(2'd2, 0, 0, 0, 0, "stop_priority");
      HALT_REQ = 1'b0; STOP_REQ = 1'b0;
      step(2'd2, 0, 0, 0, 0, "stop_irq_no_wake");
      HALT_REQ = 1'b1;
      step(2'd2, 0, 0, 0, 0, "stop_ignores_halt");
      HALT_REQ = 1'b0; IRQ_PEND = 1'b0;

      // 4 joypad wake, wait of exactly four cycles, JOYP drop does not abort
      JOYP_WAKE = 1'b1;
      step(2'd3, 0, 1, 0, 0, "osc_wait_1");
      JOYP_WAKE = 1'b0;
      step(2'd3, 0, 1, 0, 0, "osc_wait_2");
      HALT_REQ = 1'b1;
      step(2'd3, 0, 1, 0, 0, "osc_wait_3");
      HALT_REQ = 1'b0;
      step(2'd3, 0, 1, 0, 0, "osc_wait_4");
      step(2'd0, 1, 1, 0, 1, "stop_wake_ack");
      step(2'd0, 1, 1, 0, 0, "stop_ack_drop");

      // 6 reset during OSC_WAIT with counter at 2
      STOP_REQ = 1'b1;
      step(2'd2, 0, 0, 0, 0, "stop_again");
      STOP_REQ = 1'b0; JOYP_WAKE = 1'b1;
      step(2'd3, 0, 1, 0, 0, "osc_wait_cnt3");
      JOYP_WAKE = 1'b0;
      step(2'd3, 0, 1, 0, 0, "osc_wait_cnt2");
      nRESET = 1'b0;
      step(2'd0, 1, 1, 0, 0, "reset_mid_wait");
      nRESET = 1'b1;
      step(2'd0, 1, 1, 0, 0, "run_after_reset");
      step(2'd0, 1, 1, 0, 0, "run_stable");

      @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
